ahblite_slave_mux: RTL and testbench
====================================

# ahblite_slave_mux

Data-phase response multiplexer and default slave for the AHB-Lite bus, placed after the address decoder. It registers the decoder's five HSEL outputs during the address phase, then routes the selected slave's HREADYOUT, HRESP and HRDATA back to the master in the data phase. It answers any active transfer to unmapped or disabled space with a two-cycle ERROR response. It also keeps a saturating error count and the address of the most recent faulting transfer for debug.

## Interface
Parameters:
- Port0_en, 1, LED slave present; 0 forces port unselectable
- Port1_en, 1, keyboard slave present
- Port2_en, 1, RAMCODE slave present
- Port3_en, 1, RAMDATA slave present
- Port4_en, 1, LED segment slave present

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset; asynchronous, active-low
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type
- P0_HSEL..P4_HSEL  in  1 each  decoder selects
- P0_HREADYOUT..P4_HREADYOUT  in  1 each  slave ready
- P0_HRESP..P4_HRESP  in  1 each  slave response (1 = ERROR)
- P0_HRDATA..P4_HRDATA  in  32 each  slave read data
- HREADY  out  1  bus ready to master and all slaves
- HRESP  out  1  bus response
- HRDATA  out  32  bus read data
- ERR_CNT  out  8  default-slave ERROR count, saturating
- ERR_ADDR  out  32  HADDR of the last transfer answered with ERROR

## Operation
- Address phase is sampled on a rising HCLK edge with HREADY=1.
- Select register (one-hot, 6 states: P0..P4, DEFAULT) loads on each sampled address phase:
  - Pn_HSEL=1 with Port n enabled: select Pn. If several are asserted, the lowest index wins.
  - Otherwise: select DEFAULT.
- When HREADY=0 the select register holds.
- Data-phase mux, with port Pn selected:
  - HREADY = Pn_HREADYOUT
  - HRESP = Pn_HRESP
  - HRDATA = Pn_HRDATA
- Data-phase mux, with DEFAULT selected: HREADY, HRESP and HRDATA come from the default-slave FSM. HRDATA = 0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=0.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
  - IDLE → ERR1: sampled address phase selects DEFAULT and HTRANS[1]=1 (NONSEQ/SEQ).
  - ERR1 → ERR2: unconditional.
  - ERR2 → ERR1: another unmapped NONSEQ/SEQ is sampled.
  - ERR2 → IDLE: any other case.
- IDLE or BUSY to unmapped space: FSM stays IDLE, giving a zero-wait OKAY.
- ERR_CNT increments by 1 on every IDLE/ERR2 → ERR1 transition and saturates at 8'hFF.
- ERR_ADDR loads HADDR on the same edge as the ERR_CNT increment.
- ERRORs returned by real slaves are passed through and are not counted.

## Timing
- Reset values (asserted asynchronously on HRESETn=0):
  - Select = DEFAULT, FSM = IDLE
  - HREADY=1, HRESP=0, HRDATA=0
  - ERR_CNT=0, ERR_ADDR=0
- HREADY, HRESP and HRDATA are combinational from the registered select and the slave inputs. There is no added latency.
- Select, FSM and error registers change only on the rising HCLK edge, apart from reset.
- During ERR1 (HREADY=0), address-phase inputs are ignored. A master changing HTRANS to IDLE in ERR1 has no effect on the FSM.
- Back-to-back unmapped transfers yield repeating ERR1, ERR2, ERR1, ERR2.
- A mapped transfer sampled in ERR2 moves select to Pn and the FSM to IDLE on the same edge.
- Reset mid-ERR1 returns to IDLE with HREADY=1 immediately; no second ERROR cycle is issued.
- A slave HREADYOUT=0 stalls the bus. The select register must not change until that slave returns HREADYOUT=1.

## Structure
- Shared package ahblite_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HRESP encodings (OKAY=0, ERROR=1)
  - NUM_PORTS=5 and the select-state enum
- One sub-module, ahblite_default_slave, contains the IDLE/ERR1/ERR2 FSM, ERR_CNT and ERR_ADDR.
- The top level holds the select register and the response mux.

## Test plan
- Reset then NONSEQ to 0x40000010 (P0_HSEL=1), P0 drives HREADYOUT=1, HRDATA=0x000000A5 → next cycle HREADY=1, HRESP=0, HRDATA=0x000000A5.
- NONSEQ to 0x50000000 (no HSEL) → HREADY=0/HRESP=1, then HREADY=1/HRESP=1, HRDATA=0, ERR_CNT=1, ERR_ADDR=0x50000000.
- IDLE to 0x50000000 → single cycle HREADY=1, HRESP=0, ERR_CNT unchanged.
- P3 holds HREADYOUT=0 for 3 cycles while the master presents a new address → HREADY=0 for 3 cycles, select stays P3, new address sampled only on the 4th cycle.
- 256 consecutive unmapped NONSEQs → alternating ERR1/ERR2 throughout, ERR_CNT saturates at 0xFF, ERR_ADDR equals the last address.
- HRESETn pulsed low during ERR1 → HREADY=1, HRESP=0, ERR_CNT=0 immediately, with no ERR2 cycle afterward.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, port count and the data-phase select / default-slave state types.
// decode_sel turns decoder HSEL lines plus port enables into the next select value.
package ahblite_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [5:0] {
    SEL_P0      = 6'b000001,
    SEL_P1      = 6'b000010,
    SEL_P2      = 6'b000100,
    SEL_P3      = 6'b001000,
    SEL_P4      = 6'b010000,
    SEL_DEFAULT = 6'b100000
  } sel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Lowest enabled, asserted port wins; anything else lands on the default slave.
  function automatic sel_e decode_sel(input logic [NUM_PORTS-1:0] hsel,
                                      input logic [NUM_PORTS-1:0] en);
    logic [NUM_PORTS-1:0] hit;
    hit = hsel & en;
    if (hit[0])      return SEL_P0;
    else if (hit[1]) return SEL_P1;
    else if (hit[2]) return SEL_P2;
    else if (hit[3]) return SEL_P3;
    else if (hit[4]) return SEL_P4;
    else             return SEL_DEFAULT;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped space, plus a
// saturating error counter and the address of the latest faulting transfer.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        addr_phase,
  input  logic        sel_default,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  output logic        hready,
  output logic        hresp,
  output logic [7:0]  err_cnt,
  output logic [31:0] err_addr,
  output ds_state_e   state
);

  ds_state_e state_d;
  logic      start_err;

  // HTRANS[1] separates NONSEQ/SEQ from IDLE/BUSY, which get a zero-wait OKAY.
  assign start_err = addr_phase && sel_default && htrans[1];

  assign hready = (state != DS_ERR1);
  assign hresp  = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DS_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      DS_IDLE: if (start_err) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = start_err ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= 8'h00;
      err_addr <= 32'h0;
    end else if (start_err && state != DS_ERR1) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
      err_addr <= haddr;
    end
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response mux: registers the decoder select on each sampled
// address phase and routes the chosen slave (or the default slave) back to the master.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  ERR_CNT,
  output logic [31:0] ERR_ADDR
);

  localparam logic [NUM_PORTS-1:0] PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

  // Valid/ready: an address phase is taken on a rising HCLK edge only while HREADY=1;
  // a slave holding HREADYOUT=0 in its data phase freezes the select and the default FSM.
  sel_e      sel_q;
  sel_e      sel_d;
  logic      ds_hready;
  logic      ds_hresp;
  ds_state_e ds_state;

  assign sel_d = decode_sel({P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL}, PORT_EN);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= SEL_DEFAULT;
    else if (HREADY) sel_q <= sel_d;
  end

  ahblite_default_slave u_default_slave (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .addr_phase  (HREADY),
    .sel_default (sel_d == SEL_DEFAULT),
    .htrans      (HTRANS),
    .haddr       (HADDR),
    .hready      (ds_hready),
    .hresp       (ds_hresp),
    .err_cnt     (ERR_CNT),
    .err_addr    (ERR_ADDR),
    .state       (ds_state)
  );

  always_comb begin
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    HRDATA = 32'h0;
    unique case (sel_q)
      SEL_P0: begin HREADY = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
      SEL_P1: begin HREADY = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
      SEL_P2: begin HREADY = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
      SEL_P3: begin HREADY = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
      SEL_P4: begin HREADY = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
      default: ;
    endcase
  end

  // The default slave can only be mid-ERROR while it owns the data phase.
  a_err1_owns_bus: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (ds_state == DS_ERR1) |-> (sel_q == SEL_DEFAULT));

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux with port 4 disabled; one task per scenario.
module tb_ahblite_slave_mux;

  logic        clk;
  logic        rst_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [4:0]  p_hsel;
  logic [4:0]  p_hreadyout;
  logic [4:0]  p_hresp;
  logic [31:0] p_hrdata [5];
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [7:0]  err_cnt;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_fails  = 0;

  ahblite_slave_mux #(.Port4_en(1'b0)) dut (
    .HCLK         (clk),
    .HRESETn      (rst_n),
    .HADDR        (haddr),
    .HTRANS       (htrans),
    .P0_HSEL      (p_hsel[0]),
    .P1_HSEL      (p_hsel[1]),
    .P2_HSEL      (p_hsel[2]),
    .P3_HSEL      (p_hsel[3]),
    .P4_HSEL      (p_hsel[4]),
    .P0_HREADYOUT (p_hreadyout[0]),
    .P1_HREADYOUT (p_hreadyout[1]),
    .P2_HREADYOUT (p_hreadyout[2]),
    .P3_HREADYOUT (p_hreadyout[3]),
    .P4_HREADYOUT (p_hreadyout[4]),
    .P0_HRESP     (p_hresp[0]),
    .P1_HRESP     (p_hresp[1]),
    .P2_HRESP     (p_hresp[2]),
    .P3_HRESP     (p_hresp[3]),
    .P4_HRESP     (p_hresp[4]),
    .P0_HRDATA    (p_hrdata[0]),
    .P1_HRDATA    (p_hrdata[1]),
    .P2_HRDATA    (p_hrdata[2]),
    .P3_HRDATA    (p_hrdata[3]),
    .P4_HRDATA    (p_hrdata[4]),
    .HREADY       (hready),
    .HRESP        (hresp),
    .HRDATA       (hrdata),
    .ERR_CNT      (err_cnt),
    .ERR_ADDR     (err_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    htrans = 2'b00;
    haddr  = 32'h0;
    p_hsel = 5'b00000;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] addr, input logic [4:0] sel);
    htrans = tr;
    haddr  = addr;
    p_hsel = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    #2;
    n_checks++; if (hready !== 1'b1) begin n_fails++; $display("FAIL reset_hready: got %0h want 1", hready); end
    n_checks++; if (hresp !== 1'b0) begin n_fails++; $display("FAIL reset_hresp: got %0h want 0", hresp); end
    n_checks++; if (hrdata !== 32'h0) begin n_fails++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    n_checks++; if (err_addr !== 32'h0) begin n_fails++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mapped_read();
    drive(2'b10, 32'h4000_0010, 5'b00001);
    step();
    idle_bus();
    n_checks++; if (hready !== 1'b1) begin n_fails++; $display("FAIL p0_hready: got %0h want 1", hready); end
    n_checks++; if (hresp !== 1'b0) begin n_fails++; $display("FAIL p0_hresp: got %0h want 0", hresp); end
    n_checks++; if (hrdata !== 32'h0000_00A5) begin n_fails++; $display("FAIL p0_hrdata: got %h want 000000a5", hrdata); end
    step();
  endtask

  task automatic test_port_select();
    logic [4:0]  vec_sel  [5];
    logic [31:0] vec_data [5];
    logic        vec_resp [5];
    vec_sel  = '{5'b00010, 5'b00100, 5'b01000, 5'b10110, 5'b11000};
    vec_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h1111_1111, 32'h3333_3333};
    vec_resp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    p_hresp = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 32'h4000_1000 + 32'(i * 16), vec_sel[i]);
      step();
      idle_bus();
      n_checks++; if (hrdata !== vec_data[i]) begin n_fails++; $display("FAIL port_sel_data[%0d]: got %h want %h", i, hrdata, vec_data[i]); end
      n_checks++; if (hresp !== vec_resp[i]) begin n_fails++; $display("FAIL port_sel_resp[%0d]: got %0h want %0h", i, hresp, vec_resp[i]); end
    end
    step();
    p_hresp = 5'b00000;
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL slave_err_not_counted: got %h want 00", err_cnt); end
  endtask

  task automatic test_unmapped_nonseq();
    drive(2'b10, 32'h5000_0000, 5'b00000);
    step();
    // a different unmapped address during ERR1 must not be sampled
    drive(2'b10, 32'h5000_0100, 5'b00000);
    n_checks++; if ({hready, hresp} !== 2'b01) begin n_fails++; $display("FAIL unmapped_err1: got %b want 01", {hready, hresp}); end
    n_checks++; if (err_cnt !== 8'h01) begin n_fails++; $display("FAIL unmapped_cnt_err1: got %h want 01", err_cnt); end
    step();
    idle_bus();
    n_checks++; if ({hready, hresp} !== 2'b11) begin n_fails++; $display("FAIL unmapped_err2: got %b want 11", {hready, hresp}); end
    n_checks++; if (hrdata !== 32'h0) begin n_fails++; $display("FAIL unmapped_hrdata: got %h want 0", hrdata); end
    n_checks++; if (err_cnt !== 8'h01) begin n_fails++; $display("FAIL unmapped_cnt: got %h want 01", err_cnt); end
    n_checks++; if (err_addr !== 32'h5000_0000) begin n_fails++; $display("FAIL unmapped_addr: got %h want 50000000", err_addr); end
    step();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL unmapped_back_idle: got %b want 10", {hready, hresp}); end
  endtask

  task automatic test_unmapped_idle_busy();
    drive(2'b00, 32'h5000_0000, 5'b00000);
    step();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL idle_unmapped: got %b want 10", {hready, hresp}); end
    drive(2'b01, 32'h5000_0004, 5'b00000);
    step();
    idle_bus();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL busy_unmapped: got %b want 10", {hready, hresp}); end
    n_checks++; if (err_cnt !== 8'h01) begin n_fails++; $display("FAIL idle_busy_cnt: got %h want 01", err_cnt); end
  endtask

  task automatic test_disabled_port();
    drive(2'b10, 32'h5002_0000, 5'b10000);
    step();
    idle_bus();
    n_checks++; if ({hready, hresp} !== 2'b01) begin n_fails++; $display("FAIL disabled_err1: got %b want 01", {hready, hresp}); end
    n_checks++; if (hrdata !== 32'h0) begin n_fails++; $display("FAIL disabled_hrdata: got %h want 0", hrdata); end
    step();
    n_checks++; if ({hready, hresp} !== 2'b11) begin n_fails++; $display("FAIL disabled_err2: got %b want 11", {hready, hresp}); end
    n_checks++; if (err_cnt !== 8'h02) begin n_fails++; $display("FAIL disabled_cnt: got %h want 02", err_cnt); end
    n_checks++; if (err_addr !== 32'h5002_0000) begin n_fails++; $display("FAIL disabled_addr: got %h want 50020000", err_addr); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(2'b10, 32'h5003_0000, 5'b00000);
    step();
    drive(2'b10, 32'h4000_0100, 5'b00100);
    step();
    n_checks++; if ({hready, hresp} !== 2'b11) begin n_fails++; $display("FAIL b2b_err2: got %b want 11", {hready, hresp}); end
    step();
    idle_bus();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL b2b_p2_resp: got %b want 10", {hready, hresp}); end
    n_checks++; if (hrdata !== 32'h2222_2222) begin n_fails++; $display("FAIL b2b_p2_data: got %h want 22222222", hrdata); end
    n_checks++; if (err_cnt !== 8'h03) begin n_fails++; $display("FAIL b2b_cnt: got %h want 03", err_cnt); end
    step();
  endtask

  task automatic test_stall();
    p_hreadyout[3] = 1'b0;
    drive(2'b10, 32'h4000_3000, 5'b01000);
    step();
    drive(2'b10, 32'h4000_0020, 5'b00001);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      n_checks++; if (hready !== 1'b0) begin n_fails++; $display("FAIL stall_hready[%0d]: got %0h want 0", c, hready); end
      n_checks++; if (hrdata !== 32'h3333_3333) begin n_fails++; $display("FAIL stall_sel[%0d]: got %h want 33333333", c, hrdata); end
    end
    step();
    p_hreadyout[3] = 1'b1;
    #1;
    n_checks++; if (hready !== 1'b1) begin n_fails++; $display("FAIL stall_release: got %0h want 1", hready); end
    n_checks++; if (hrdata !== 32'h3333_3333) begin n_fails++; $display("FAIL stall_release_data: got %h want 33333333", hrdata); end
    step();
    idle_bus();
    n_checks++; if (hrdata !== 32'h0000_00A5) begin n_fails++; $display("FAIL stall_next_addr: got %h want 000000a5", hrdata); end
    step();
  endtask

  task automatic test_saturation();
    logic [31:0] addr;
    logic [7:0]  exp_cnt;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      addr = 32'h5000_0000 + 32'(i * 4);
      exp_cnt = (i >= 254) ? 8'hFF : 8'(i + 1);
      drive(2'b10, addr, 5'b00000);
      step();
      if (i < 255) drive(2'b10, addr + 32'h4, 5'b00000);
      else idle_bus();
      n_checks++; if ({hready, hresp} !== 2'b01) begin n_fails++; $display("FAIL sat_err1[%0d]: got %b want 01", i, {hready, hresp}); end
      step();
      n_checks++; if ({hready, hresp} !== 2'b11) begin n_fails++; $display("FAIL sat_err2[%0d]: got %b want 11", i, {hready, hresp}); end
      n_checks++; if (err_cnt !== exp_cnt) begin n_fails++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, err_cnt, exp_cnt); end
      n_checks++; if (err_addr !== addr) begin n_fails++; $display("FAIL sat_addr[%0d]: got %h want %h", i, err_addr, addr); end
    end
    step();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL sat_idle: got %b want 10", {hready, hresp}); end
    n_checks++; if (err_cnt !== 8'hFF) begin n_fails++; $display("FAIL sat_final_cnt: got %h want ff", err_cnt); end
    n_checks++; if (err_addr !== 32'h5000_03FC) begin n_fails++; $display("FAIL sat_final_addr: got %h want 500003fc", err_addr); end
  endtask

  task automatic test_reset_mid_err1();
    drive(2'b10, 32'h5004_0000, 5'b00000);
    step();
    idle_bus();
    n_checks++; if ({hready, hresp} !== 2'b01) begin n_fails++; $display("FAIL rst_pre_err1: got %b want 01", {hready, hresp}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL rst_mid_err1: got %b want 10", {hready, hresp}); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL rst_mid_cnt: got %h want 00", err_cnt); end
    n_checks++; if (err_addr !== 32'h0) begin n_fails++; $display("FAIL rst_mid_addr: got %h want 0", err_addr); end
    #2;
    rst_n = 1'b1;
    step();
    n_checks++; if ({hready, hresp} !== 2'b10) begin n_fails++; $display("FAIL rst_no_err2: got %b want 10", {hready, hresp}); end
  endtask

  initial begin
    p_hreadyout = 5'b11111;
    p_hresp     = 5'b00000;
    p_hrdata[0] = 32'h0000_00A5;
    p_hrdata[1] = 32'h1111_1111;
    p_hrdata[2] = 32'h2222_2222;
    p_hrdata[3] = 32'h3333_3333;
    p_hrdata[4] = 32'h4444_4444;
    test_reset();
    test_mapped_read();
    test_port_select();
    test_unmapped_nonseq();
    test_unmapped_idle_busy();
    test_disabled_port();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_mid_err1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
